// File: rtl/conv_stream_layer_pkg.sv
// Shared types and sizing helpers for the streaming convolution layer.
// Arithmetic helpers are constant functions so they can size localparams.
package conv_pkg;

   typedef enum logic {
      LOAD,
      RUN
   } state_t;

   function automatic int acc_width(input int px_size, input int k, input int c);
      return 2 * px_size + $clog2(k * k * c) + 1;
   endfunction

   function automatic int num_weights(input int oc, input int k);
      return oc * k * k;
   endfunction

   // Negative sums clamp to zero; positive sums are scaled down and clipped to the pixel range.
   function automatic longint sat_relu(input longint acc, input int shift, input int px_size);
      longint shifted;
      longint maxval;
      maxval = (longint'(1) <<< px_size) - 1;
      if (acc < 0) begin
         return 0;
      end
      shifted = acc >>> shift;
      if (shifted > maxval) begin
         shifted = maxval;
      end
      return shifted;
   endfunction

endpackage

// File: rtl/conv_stream_layer_line_buffer.sv
// One image row of delay: each enabled beat shifts a pixel in and exposes
// the pixel that entered DEPTH beats earlier.
module line_buffer
   import conv_pkg::*;
#(
   parameter int DEPTH = 5,
   parameter int WIDTH = 24
)
(
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Contents are never cleared; the parent only consumes rows it has fully written.
   always_ff @(posedge clk) begin
      if (en) begin
         mem[0] <= din;
         for (int i = 1; i < DEPTH; i++) begin
            mem[i] <= mem[i-1];
         end
      end
   end

   assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv_stream_layer.sv
// Streaming multi-output-channel convolution: raster pixels in, one registered
// result per window position out, kernels loaded serially through the weight port.
module conv_stream_layer
   import conv_pkg::*;
#(
   parameter int INPUT_SIZE      = 5,
   parameter int INPUT_CHANNELS  = 3,
   parameter int OUTPUT_CHANNELS = 2,
   parameter int KERNEL_SIZE     = 3,
   parameter int STRIDE          = 1,
   parameter int PX_SIZE         = 8,
   parameter int SHIFT           = 0
)
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   output logic                               in_ready,
   input  logic [INPUT_CHANNELS*PX_SIZE-1:0]  in_data,
   input  logic                               w_valid,
   output logic                               w_ready,
   input  logic [INPUT_CHANNELS*PX_SIZE-1:0]  w_data,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [OUTPUT_CHANNELS*PX_SIZE-1:0] out_data,
   output logic                               weights_loaded
);

   localparam int K     = KERNEL_SIZE;
   localparam int PXW   = INPUT_CHANNELS * PX_SIZE;
   localparam int NW    = num_weights(OUTPUT_CHANNELS, K);
   localparam int ACC_W = acc_width(PX_SIZE, K, INPUT_CHANNELS);
   localparam int CW    = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;
   localparam int WIW   = (NW > 1) ? $clog2(NW) : 1;
   localparam logic [CW-1:0]  LAST  = CW'(INPUT_SIZE - 1);
   localparam logic [WIW-1:0] WLAST = WIW'(NW - 1);

   state_t           state_q;
   state_t           state_d;
   logic [WIW-1:0]   widx_q;
   logic [CW-1:0]    row_q;
   logic [CW-1:0]    col_q;
   logic [PXW-1:0]   wts_q [NW];
   logic [PXW-1:0]   win_q [K][K];
   logic [PXW-1:0]   win_d [K][K];
   logic [PXW-1:0]   colv  [K];
   logic             in_fire;
   logic             w_fire;
   logic             hit;
   logic             frame_start;
   logic [OUTPUT_CHANNELS*PX_SIZE-1:0] result;

   assign in_fire     = in_valid && in_ready;
   assign w_fire      = w_valid && w_ready;
   assign frame_start = (row_q == '0) && (col_q == '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Reloading is only allowed between frames with no result pending, so a kernel never changes mid-frame.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      w_ready  = 1'b0;
      case (state_q)
         LOAD: begin
            w_ready = 1'b1;
            if (w_valid && (widx_q == WLAST)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            in_ready = !out_valid || out_ready;
            w_ready  = frame_start && !out_valid;
            if (w_valid && frame_start && !out_valid && (NW > 1)) begin
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         widx_q         <= '0;
         weights_loaded <= 1'b0;
         for (int i = 0; i < NW; i++) begin
            wts_q[i] <= '0;
         end
      end else if (w_fire) begin
         if (state_q == LOAD) begin
            wts_q[widx_q] <= w_data;
            if (widx_q == WLAST) begin
               widx_q         <= '0;
               weights_loaded <= 1'b1;
            end else begin
               widx_q <= widx_q + 1'b1;
            end
         end else begin
            wts_q[0]       <= w_data;
            widx_q         <= (NW > 1) ? WIW'(1) : '0;
            weights_loaded <= (NW == 1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else if (in_fire) begin
         if (col_q == LAST) begin
            col_q <= '0;
            row_q <= (row_q == LAST) ? '0 : row_q + 1'b1;
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   // colv[K-1] is the current row; each line buffer steps one row further back.
   assign colv[K-1] = in_data;
   for (genvar i = 0; i < K - 1; i++) begin : g_lb
      line_buffer #(
         .DEPTH (INPUT_SIZE),
         .WIDTH (PXW)
      ) u_lb (
         .clk  (clk),
         .en   (in_fire),
         .din  (colv[K-1-i]),
         .dout (colv[K-2-i])
      );
   end

   always_comb begin
      for (int ky = 0; ky < K; ky++) begin
         win_d[ky][K-1] = colv[ky];
         for (int kx = 0; kx < K - 1; kx++) begin
            win_d[ky][kx] = win_q[ky][kx+1];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) begin
         for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
               win_q[ky][kx] <= win_d[ky][kx];
            end
         end
      end
   end

   // The MAC reads the post-shift window so the result registers on the same edge that completes it.
   always_comb begin : mac
      logic signed [ACC_W-1:0]   acc;
      logic signed [ACC_W-1:0]   prod;
      logic signed [PX_SIZE:0]   pxs;
      logic signed [PX_SIZE-1:0] ws;
      result = '0;
      acc    = '0;
      prod   = '0;
      pxs    = '0;
      ws     = '0;
      for (int oc = 0; oc < OUTPUT_CHANNELS; oc++) begin
         acc = '0;
         for (int ky = 0; ky < K; ky++) begin
            for (int kx = 0; kx < K; kx++) begin
               for (int ci = 0; ci < INPUT_CHANNELS; ci++) begin
                  pxs  = signed'({1'b0, win_d[ky][kx][ci*PX_SIZE +: PX_SIZE]});
                  ws   = signed'(wts_q[oc*K*K + ky*K + kx][ci*PX_SIZE +: PX_SIZE]);
                  prod = pxs * ws;
                  acc  = acc + prod;
               end
            end
         end
         result[oc*PX_SIZE +: PX_SIZE] = PX_SIZE'(sat_relu(longint'(acc), SHIFT, PX_SIZE));
      end
   end

   always_comb begin
      hit = (int'(row_q) >= K - 1) && (int'(col_q) >= K - 1) &&
            (((int'(row_q) - (K - 1)) % STRIDE) == 0) &&
            (((int'(col_q) - (K - 1)) % STRIDE) == 0);
   end

   // A new result may overwrite the old one only when the old one is leaving in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (in_fire && hit) begin
         out_valid <= 1'b1;
         out_data  <= result;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_conv_stream_layer.sv
// Scoreboard bench: three layer instances (baseline, SHIFT=5, STRIDE=2) driven
// one at a time; expected results are queued on issue and popped by monitors.
module tb_conv_stream_layer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ivalid = 1'b0;
   logic        wvalid = 1'b0;
   logic        ordy = 1'b1;
   logic [23:0] idata = '0;
   logic [23:0] wdata = '0;
   int          sel = 0;

   logic        iv [3];
   logic        wv [3];
   logic        ir [3];
   logic        wr [3];
   logic        ov [3];
   logic        wl [3];
   logic [15:0] od [3];

   logic [15:0] q0 [$];
   logic [15:0] q1 [$];
   logic [15:0] q2 [$];

   int cmpCount = 0;
   int errCount = 0;

   int          pos1 [9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};
   int          pos2 [4] = '{12, 14, 22, 24};
   logic [15:0] expA [9] = '{{8'd54, 8'd6},   {8'd63, 8'd7},   {8'd72, 8'd8},
                              {8'd99, 8'd11},  {8'd108, 8'd12}, {8'd117, 8'd13},
                              {8'd144, 8'd16}, {8'd153, 8'd17}, {8'd162, 8'd18}};
   logic [15:0] expS [4] = '{{8'd54, 8'd6}, {8'd72, 8'd8}, {8'd144, 8'd16}, {8'd162, 8'd18}};

   always #5 clk = ~clk;

   assign iv[0] = ivalid && (sel == 0);
   assign iv[1] = ivalid && (sel == 1);
   assign iv[2] = ivalid && (sel == 2);
   assign wv[0] = wvalid && (sel == 0);
   assign wv[1] = wvalid && (sel == 1);
   assign wv[2] = wvalid && (sel == 2);

   conv_stream_layer #(.INPUT_SIZE(5), .INPUT_CHANNELS(3), .OUTPUT_CHANNELS(2), .KERNEL_SIZE(3),
                       .STRIDE(1), .PX_SIZE(8), .SHIFT(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idata),
      .w_valid(wv[0]), .w_ready(wr[0]), .w_data(wdata), .out_valid(ov[0]),
      .out_ready(ordy), .out_data(od[0]), .weights_loaded(wl[0]));

   conv_stream_layer #(.INPUT_SIZE(5), .INPUT_CHANNELS(3), .OUTPUT_CHANNELS(2), .KERNEL_SIZE(3),
                       .STRIDE(1), .PX_SIZE(8), .SHIFT(5)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idata),
      .w_valid(wv[1]), .w_ready(wr[1]), .w_data(wdata), .out_valid(ov[1]),
      .out_ready(ordy), .out_data(od[1]), .weights_loaded(wl[1]));

   conv_stream_layer #(.INPUT_SIZE(5), .INPUT_CHANNELS(3), .OUTPUT_CHANNELS(2), .KERNEL_SIZE(3),
                       .STRIDE(2), .PX_SIZE(8), .SHIFT(0)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(idata),
      .w_valid(wv[2]), .w_ready(wr[2]), .w_data(wdata), .out_valid(ov[2]),
      .out_ready(ordy), .out_data(od[2]), .weights_loaded(wl[2]));

   task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] expv);
      cmpCount++;
      if (got !== expv) begin
         errCount++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, got, expv);
      end
   endtask

   task automatic checkOutput(input int inst, input logic [15:0] got);
      logic [15:0] expv;
      bit          have;
      have = 1'b0;
      expv = '0;
      case (inst)
         0: if (q0.size() > 0) begin expv = q0.pop_front(); have = 1'b1; end
         1: if (q1.size() > 0) begin expv = q1.pop_front(); have = 1'b1; end
         default: if (q2.size() > 0) begin expv = q2.pop_front(); have = 1'b1; end
      endcase
      cmpCount++;
      if (!have) begin
         errCount++;
         $display("[TB] FAIL out%0d unexpected: got %h expected none", inst, got);
      end else if (got !== expv) begin
         errCount++;
         $display("[TB] FAIL out%0d data: got %h expected %h", inst, got, expv);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (ov[i] && ordy) checkOutput(i, od[i]);
         end
      end
   end

   function automatic logic [23:0] pixelOf(input int pat, input int p);
      int r;
      int c;
      r = p / 5;
      c = p % 5;
      case (pat)
         0: return {16'h0000, 8'(p)};
         1: return 24'hFFFFFF;
         default: return {8'(r + 1), 8'(c + 1), 8'(p + 1)};
      endcase
   endfunction

   // mode: 0 kernel-A raster, 1 ReLU, 2 saturate, 3 saturate with SHIFT=5, 4 stride 2, 5 none
   function automatic int posIndex(input int mode, input int p);
      if (mode == 5) return -1;
      if (mode == 4) begin
         for (int k = 0; k < 4; k++) if (pos2[k] == p) return k;
         return -1;
      end
      for (int k = 0; k < 9; k++) if (pos1[k] == p) return k;
      return -1;
   endfunction

   function automatic logic [15:0] expFor(input int mode, input int k);
      case (mode)
         0: return expA[k];
         1: return 16'h0000;
         2: return 16'hFFFF;
         3: return {8'd215, 8'd215};
         default: return expS[k];
      endcase
   endfunction

   task automatic applyStimulus(input int s, input logic [23:0] d);
      int n;
      n = 0;
      sel = s;
      idata = d;
      ivalid = 1'b1;
      @(negedge clk);
      while (!ir[s] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!ir[s]) begin
         cmpCount++;
         errCount++;
         $display("[TB] FAIL in_ready%0d timeout: got 0 expected 1", s);
         ivalid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      ivalid = 1'b0;
   endtask

   task automatic loadWeight(input int s, input logic [23:0] d);
      int n;
      n = 0;
      sel = s;
      wdata = d;
      wvalid = 1'b1;
      @(negedge clk);
      while (!wr[s] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!wr[s]) begin
         cmpCount++;
         errCount++;
         $display("[TB] FAIL w_ready%0d timeout: got 0 expected 1", s);
         wvalid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      wvalid = 1'b0;
   endtask

   // kind: 0 centre/box kernel pair, 1 all -1, 2 all +1
   task automatic loadKernel(input int s, input int kind, input bit checkMid);
      logic [23:0] w;
      for (int i = 0; i < 18; i++) begin
         case (kind)
            0: w = (i == 4 || i >= 9) ? 24'h000001 : 24'h000000;
            1: w = 24'hFFFFFF;
            default: w = 24'h010101;
         endcase
         loadWeight(s, w);
         if (checkMid && i == 0) begin
            checkValue("reload_loaded_drop", 32'(wl[s]), 32'd0);
            checkValue("reload_in_ready", 32'(ir[s]), 32'd0);
         end
         if (checkMid && i == 9) checkValue("load_in_ready", 32'(ir[s]), 32'd0);
      end
      checkValue("weights_loaded", 32'(wl[s]), 32'd1);
      checkValue("run_in_ready", 32'(ir[s]), 32'd1);
   endtask

   task automatic sendPixels(input int s, input int pat, input int mode, input int first, input int last);
      int k;
      for (int p = first; p <= last; p++) begin
         k = posIndex(mode, p);
         if (k >= 0) begin
            case (s)
               0: q0.push_back(expFor(mode, k));
               1: q1.push_back(expFor(mode, k));
               default: q2.push_back(expFor(mode, k));
            endcase
         end
         applyStimulus(s, pixelOf(pat, p));
      end
   endtask

   task automatic stallOutput();
      logic [15:0] held;
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ov[0] && n < 200);
      if (!ov[0]) begin
         cmpCount++;
         errCount++;
         $display("[TB] FAIL stall_wait: got out_valid 0 expected 1");
         return;
      end
      ordy = 1'b0;
      held = od[0];
      repeat (5) begin
         @(negedge clk);
         checkValue("stall_in_ready", 32'(ir[0]), 32'd0);
         checkValue("stall_out_valid", 32'(ov[0]), 32'd1);
         checkValue("stall_out_data", 32'(od[0]), 32'(held));
      end
      @(posedge clk);
      #1;
      ordy = 1'b1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #12;
      checkValue("rst_out_valid", 32'(ov[0]), 32'd0);
      checkValue("rst_out_data", 32'(od[0]), 32'd0);
      checkValue("rst_in_ready", 32'(ir[0]), 32'd0);
      checkValue("rst_w_ready", 32'(wr[0]), 32'd1);
      checkValue("rst_loaded", 32'(wl[0]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      loadKernel(0, 0, 1'b1);
      sendPixels(0, 0, 0, 0, 24);

      fork
         sendPixels(0, 0, 0, 0, 24);
         stallOutput();
      join

      sendPixels(0, 0, 0, 0, 6);
      checkValue("midframe_w_ready", 32'(wr[0]), 32'd0);
      sel = 0;
      wdata = 24'h0000FF;
      wvalid = 1'b1;
      @(posedge clk);
      #1;
      wvalid = 1'b0;
      checkValue("midframe_loaded", 32'(wl[0]), 32'd1);
      sendPixels(0, 0, 0, 7, 24);

      loadKernel(0, 1, 1'b1);
      sendPixels(0, 2, 1, 0, 24);
      loadKernel(0, 2, 1'b0);
      sendPixels(0, 1, 2, 0, 24);

      loadKernel(1, 2, 1'b0);
      sendPixels(1, 1, 3, 0, 24);

      loadKernel(2, 0, 1'b0);
      sendPixels(2, 0, 4, 0, 24);

      repeat (3) @(posedge clk);
      #1;
      sendPixels(0, 0, 5, 0, 11);
      ordy = 1'b0;
      applyStimulus(0, pixelOf(0, 12));
      checkValue("pre_rst_out_valid", 32'(ov[0]), 32'd1);
      #1;
      rst = 1'b1;
      #1;
      checkValue("async_rst_out_valid", 32'(ov[0]), 32'd0);
      checkValue("async_rst_out_data", 32'(od[0]), 32'd0);
      checkValue("async_rst_in_ready", 32'(ir[0]), 32'd0);
      checkValue("async_rst_w_ready", 32'(wr[0]), 32'd1);
      checkValue("async_rst_loaded", 32'(wl[0]), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ordy = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checkValue("post_rst_in_ready", 32'(ir[0]), 32'd0);
      checkValue("post_rst_w_ready", 32'(wr[0]), 32'd1);

      repeat (5) @(posedge clk);
      #1;
      checkValue("queues_empty", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCount, errCount);
      $finish;
   end

endmodule

// File: doc/conv_stream_layer.md
# conv_stream_layer

Streaming, multi-output-channel convolution layer that accepts one image pixel per beat in raster order and emits one output pixel per beat. Each output pixel carries all output channels. It replaces the fully parallel, combinational per-pixel array with line buffers, a sliding window and a registered valid/ready pipeline. Kernels are loaded serially at run time. A chain of these blocks forms the CNN feature-extraction datapath.

## Interface
- INPUT_SIZE, 5, square input width/height in pixels
- INPUT_CHANNELS, 3, channels per input pixel
- OUTPUT_CHANNELS, 2, kernels applied in parallel
- KERNEL_SIZE, 3, square kernel size K, 1 ≤ K ≤ INPUT_SIZE
- STRIDE, 1, window step in both axes
- PX_SIZE, 8, bits per pixel and per weight
- SHIFT, 0, arithmetic right shift applied before saturation
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  input pixel valid
- in_ready  out  1  input pixel accepted when in_valid & in_ready
- in_data  in  INPUT_CHANNELS*PX_SIZE  unsigned pixel; channel 0 in LSBs
- w_valid  in  1  weight word valid
- w_ready  out  1  weight word accepted when w_valid & w_ready
- w_data  in  INPUT_CHANNELS*PX_SIZE  one signed tap for all input channels; channel 0 in LSBs
- out_valid  out  1  output pixel valid
- out_ready  in  1  downstream accepts on out_valid & out_ready
- out_data  out  OUTPUT_CHANNELS*PX_SIZE  unsigned result; output channel 0 in LSBs
- weights_loaded  out  1  full kernel set present

## Operation
- NW = OUTPUT_CHANNELS*K*K weight words. Order: output channel major, then ky, then kx.
- States:
  - LOAD: w_ready=1, in_ready=0. Each accepted word is written at index widx, then widx++. After word NW-1 is accepted, go to RUN and set weights_loaded=1.
  - RUN: in_ready = !out_valid | out_ready. w_ready=1 only at a frame boundary (row=col=0 and !out_valid). An accepted weight word in RUN is written at index 0, sets widx=1 and weights_loaded=0, and returns the state to LOAD.
- Pixel counters col/row count 0..INPUT_SIZE-1 on each accepted pixel. col wraps and increments row. At (SIZE-1, SIZE-1) both wrap to 0 (end of frame).
- K-1 line buffers of INPUT_SIZE pixels plus a K×K window register hold the most recent rows. The window is updated on each accepted pixel.
- An output is produced for the pixel accepted at (row,col) iff all of the following hold:
  - row ≥ K-1 and col ≥ K-1
  - (row-K+1) % STRIDE = 0
  - (col-K+1) % STRIDE = 0
- Outputs per frame = ((INPUT_SIZE-K)/STRIDE+1)², emitted in raster order.
- Arithmetic, per output channel:
  - acc = Σ over ky,kx,ci of unsigned px × signed w.
  - ACC_W = 2*PX_SIZE + clog2(K*K*INPUT_CHANNELS) + 1, signed.
  - Result: if acc < 0 then 0 (ReLU). Otherwise acc >>> SHIFT, then saturate to 2^PX_SIZE-1.
- Line buffer contents are not cleared between frames; stale rows are never used because of the output gating above.

## Timing
- Reset values: state=LOAD, widx=0, row=col=0, weights=0, weights_loaded=0, out_valid=0, out_data=0, in_ready=0, w_ready=1.
- Latency: out_valid rises on the clock edge that accepts the window-completing pixel, i.e. 1 cycle registered.
- Backpressure: while out_valid & !out_ready, out_data is held stable and in_ready=0. Nothing is dropped or duplicated.
- Simultaneous out handshake and in handshake in the same cycle: the new result replaces the old one, giving full throughput of 1 pixel/cycle.
- A frame-end pixel that also produces an output is legal. The counters wrap on the same edge.
- Reset asserted mid-frame or mid-load: all state returns to the reset values immediately (asynchronously). Partial weights are discarded.

## Structure
- conv_pkg:
  - state enum {LOAD, RUN}
  - ACC_W function
  - sat_relu function (ReLU, shift, saturate)
  - NW localparam helper
- Sub-module line_buffer: an INPUT_SIZE-deep shift memory with enable, instantiated K-1 times.
- The MAC tree is combinational from the window and weight registers into the output register.

## Test plan
Default configuration for all tests: INPUT_SIZE=5, C=3, K=3, OUT_CH=2, SHIFT=0, and unless stated, STRIDE=1.
- Load and convolve:
  - Weights: oc0 = centre tap ch0 = 1, all others 0; oc1 = all taps ch0 = 1.
  - Input: ch0 = 5r+c, other channels 0.
  - Required: oc0 outputs 6,7,8,11,12,13,16,17,18 and oc1 outputs 54,63,72,99,108,117,144,153,162; exactly 9 outputs, then the frame restarts cleanly.
- ReLU: with all taps = -1 (0xFF) and any nonzero input, every output is 0.
- Saturation: all pixels 255 and all taps 1 → acc = 6885, output 255. With SHIFT=5, output 215.
- Backpressure:
  - Drive out_ready=0 for 5 cycles while out_valid=1.
  - Required: in_ready=0 and out_data stable throughout.
  - Afterwards, the output sequence is identical to the no-stall run.
- STRIDE=2, same weights as the first test: oc0 outputs 6,8,16,18 only.
- Reload and reset:
  - Accept a new weight word mid-frame: must be refused (w_ready=0).
  - At the frame boundary it is accepted: weights_loaded drops and in_ready=0 until NW words have been accepted.
  - Async rst mid-frame: out_valid=0 and state=LOAD with no clock edge.
